// File: rtl/sal_axi_rd_responder_if.sv
// sal_axi_rd_responder_if: AXI AR/R channels plus the per-beat backend request/response bundle
interface sal_axi_rd_responder_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready, req_ready, rsp_valid, rsp_data,
    output arready, rvalid, rid, rdata, rresp, rlast, req_valid, req_addr
  );
  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready, req_ready, rsp_valid, rsp_data,
    input  arready, rvalid, rid, rdata, rresp, rlast, req_valid, req_addr
  );
endinterface

// File: rtl/sal_axi_rd_responder.sv
// sal_axi_rd_responder: expands AR bursts into backend beat requests and returns in-order R data
module sal_axi_rd_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int DATA_DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  sal_axi_rd_responder_if.slave bus
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t                state;
  logic                  arready_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat;
  logic [2:0]            size_q;
  logic                  fixed_q;
  logic [CW-1:0]         credits;
  logic [CW-1:0]         tag_wr, tag_rd, dat_wr, dat_rd;
  logic [ID_WIDTH-1:0]   tag_id [DATA_DEPTH];
  logic                  tag_last [DATA_DEPTH];
  logic [ID_WIDTH-1:0]   dat_id [DATA_DEPTH];
  logic                  dat_last [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] dat_data [DATA_DEPTH];
  logic                  tag_empty, dat_empty, req_fire, rsp_fire, r_fire;
  assign tag_empty     = tag_wr == tag_rd;
  assign dat_empty     = dat_wr == dat_rd;
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign rsp_fire      = bus.rsp_valid && !tag_empty;
  assign r_fire        = bus.rvalid && bus.rready;
  assign bus.arready   = arready_q;
  assign bus.req_valid = state == ISSUE && credits != '0;
  assign bus.req_addr  = addr_q;
  assign bus.rvalid    = !dat_empty;
  assign bus.rid       = dat_empty ? '0 : dat_id[dat_rd[AW-1:0]];
  assign bus.rdata     = dat_empty ? '0 : dat_data[dat_rd[AW-1:0]];
  assign bus.rlast     = dat_empty ? 1'b0 : dat_last[dat_rd[AW-1:0]];
  assign bus.rresp     = 2'b00;
  // Burst sequencer: accept one AR, then walk its beats until the last request is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat      <= '0;
      size_q    <= '0;
      fixed_q   <= 1'b0;
    end else if (state == IDLE) begin
      arready_q <= !(bus.arvalid && arready_q);
      if (bus.arvalid && arready_q) begin
        state   <= ISSUE;
        id_q    <= bus.arid;
        addr_q  <= bus.araddr;
        len_q   <= bus.arlen;
        size_q  <= bus.arsize;
        fixed_q <= bus.arburst == 2'b00;
        beat    <= '0;
      end
    end else if (req_fire) begin
      beat   <= beat + 8'd1;
      addr_q <= fixed_q ? addr_q : addr_q + (ADDR_WIDTH'(1) << size_q);
      if (beat == len_q) begin
        state     <= IDLE;
        arready_q <= 1'b1;
      end
    end
  end
  // Credits reserve a data FIFO slot per issued beat, since backend data cannot be stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credits <= CW'(DATA_DEPTH);
    else credits <= credits - CW'(req_fire) + CW'(r_fire);
  end
  // FIFO pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr <= '0;
      tag_rd <= '0;
      dat_wr <= '0;
      dat_rd <= '0;
    end else begin
      tag_wr <= tag_wr + CW'(req_fire);
      tag_rd <= tag_rd + CW'(rsp_fire);
      dat_wr <= dat_wr + CW'(rsp_fire);
      dat_rd <= dat_rd + CW'(r_fire);
    end
  end
  // FIFO storage needs no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_id[tag_wr[AW-1:0]]   <= id_q;
      tag_last[tag_wr[AW-1:0]] <= beat == len_q;
    end
    if (rsp_fire) begin
      dat_id[dat_wr[AW-1:0]]   <= tag_id[tag_rd[AW-1:0]];
      dat_last[dat_wr[AW-1:0]] <= tag_last[tag_rd[AW-1:0]];
      dat_data[dat_wr[AW-1:0]] <= bus.rsp_data;
    end
  end
endmodule

// File: tb/tb_sal_axi_rd_responder.sv
// tb_sal_axi_rd_responder: table, directed and random bursts checked against a burst-level model
module tb_sal_axi_rd_responder;
  localparam int IW = 4, AWD = 32, DW = 128, DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sal_axi_rd_responder_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW)) bus ();
  sal_axi_rd_responder #(.ID_WIDTH(IW), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  typedef struct { logic [IW-1:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } ar_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic last; } r_t;
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  typedef struct { ar_t ar; logic [31:0] last_addr; } vec_t;
  ar_t         ar_q[$];
  r_t          exp_r[$];
  r_t          got[$];
  logic [31:0] exp_req[$];
  rsp_t        pend[$];
  int checks = 0, failures = 0, cyc = 0;
  int rready_mode = 1, req_ready_mode = 1, spur = 0;
  longint ref_seq = 0, bk_seq = 0;
  int req_fires = 0, r_beats = 0, rlasts = 0;
  int ar_cyc = 0, first_req_cyc = -1, last_req_cyc = 0, rise_cyc = 0, rsp_first_cyc = -1, rv_first_cyc = -1;
  logic [31:0] last_req_addr = '0;
  logic prev_stall = 1'b0, prev_arready = 1'b0, tog = 1'b0;
  r_t held;

  function automatic void chk(string nm, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // backend data tags each beat with its global issue order and address
  function automatic logic [DW-1:0] mkdata(longint s, logic [31:0] a);
    return {64'(s), ~a, a};
  endfunction

  // 0 low, 1 high, 2 toggle each cycle, 3 random
  function automatic logic pick(int m);
    return m == 0 ? 1'b0 : m == 1 ? 1'b1 : m == 2 ? tog : 1'($urandom_range(0, 1));
  endfunction

  // reference: every accepted AR expands to len+1 beats in acceptance order
  function automatic void model(ar_t a);
    logic [31:0] ad;
    for (int i = 0; i <= int'(a.len); i++) begin
      ad = a.burst == 2'b00 ? a.addr : a.addr + 32'(i) * (32'd1 << a.size);
      exp_req.push_back(ad);
      exp_r.push_back('{a.id, mkdata(ref_seq, ad), i == int'(a.len)});
      ref_seq++;
    end
  endfunction

  // all inputs are driven and all outputs sampled on the falling edge
  always @(negedge clk) begin
    r_t e;
    cyc++;
    tog = ~tog;
    if (!rst_n) begin
      bus.arvalid = 1'b0; bus.rready = 1'b0; bus.req_ready = 1'b0; bus.rsp_valid = 1'b0;
      prev_stall = 1'b0; prev_arready = 1'b0;
    end else begin
      if (bus.arready && !prev_arready) rise_cyc = cyc;
      prev_arready = bus.arready;
      if (prev_stall) begin
        chk("r_hold_valid", bus.rvalid, 1);
        chk("r_hold_beat", {bus.rid, bus.rlast, bus.rdata}, {held.id, held.last, held.data});
      end
      if (bus.rvalid && rv_first_cyc < 0) rv_first_cyc = cyc;
      bus.rready = pick(rready_mode);
      if (bus.rvalid) begin
        if (bus.rready) begin
          if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
          else begin
            e = exp_r.pop_front();
            chk("r_beat", {bus.rid, bus.rlast, bus.rresp, bus.rdata}, {e.id, e.last, 2'b00, e.data});
            got.push_back('{bus.rid, bus.rdata, bus.rlast});
            r_beats++;
            if (bus.rlast) rlasts++;
          end
        end
        held = '{bus.rid, bus.rdata, bus.rlast};
      end
      prev_stall = bus.rvalid && !bus.rready;
      bus.req_ready = pick(req_ready_mode);
      if (bus.req_valid) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          chk("req_addr", bus.req_addr, exp_req[0]);
          if (bus.req_ready) begin
            void'(exp_req.pop_front());
            pend.push_back('{cyc + 2, mkdata(bk_seq, bus.req_addr)});
            bk_seq++;
            req_fires++;
            last_req_cyc = cyc;
            last_req_addr = bus.req_addr;
          end
        end
      end
      if (pend.size() != 0 && pend[0].due == cyc) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data = pend[0].data;
        void'(pend.pop_front());
        if (rsp_first_cyc < 0) rsp_first_cyc = cyc;
      end else if (spur > 0) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data = {$urandom, $urandom, $urandom, $urandom};
        spur--;
      end else bus.rsp_valid = 1'b0;
      if (ar_q.size() != 0) begin
        bus.arvalid = 1'b1;
        bus.arid = ar_q[0].id; bus.araddr = ar_q[0].addr; bus.arlen = ar_q[0].len;
        bus.arsize = ar_q[0].size; bus.arburst = ar_q[0].burst;
        if (bus.arready) begin
          model(ar_q[0]);
          void'(ar_q.pop_front());
          ar_cyc = cyc; first_req_cyc = -1; rsp_first_cyc = -1; rv_first_cyc = -1;
        end
      end else bus.arvalid = 1'b0;
    end
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((ar_q.size() != 0 || exp_r.size() != 0 || exp_req.size() != 0 || pend.size() != 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk(nm, n < 20000, 1);
  endtask

  task automatic stall_check(input string nm, input logic [IW-1:0] id, input logic [31:0] addr);
    int r0, b0;
    rready_mode = 0;
    r0 = req_fires;
    ar_q.push_back('{id, addr, 8'd15, 3'd4, 2'b01});
    repeat (40) @(posedge clk);
    chk({nm, "_req_count"}, req_fires - r0, DEPTH);
    #1;
    chk({nm, "_req_valid"}, bus.req_valid, 0);
    chk({nm, "_rvalid"}, bus.rvalid, 1);
    b0 = r_beats;
    rready_mode = 1;
    drain({nm, "_drain"});
    chk({nm, "_beats"}, r_beats - b0, 16);
  endtask

  initial begin
    vec_t tbl[7];
    ar_t ra;
    int r0, l0, n;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.rready = 1'b0; bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
    tbl[0] = '{'{4'd3, 32'h0000_0100, 8'd0, 3'd4, 2'b01}, 32'h0000_0100};
    tbl[1] = '{'{4'd5, 32'h0000_1000, 8'd3, 3'd4, 2'b01}, 32'h0000_1030};
    tbl[2] = '{'{4'd6, 32'h0000_2000, 8'd3, 3'd4, 2'b00}, 32'h0000_2000};
    tbl[3] = '{'{4'd7, 32'hFFFF_FFF0, 8'd1, 3'd4, 2'b01}, 32'h0000_0000};
    tbl[4] = '{'{4'd8, 32'h0000_0040, 8'd2, 3'd2, 2'b10}, 32'h0000_0048};
    tbl[5] = '{'{4'd9, 32'h0000_0080, 8'd1, 3'd0, 2'b11}, 32'h0000_0081};
    tbl[6] = '{'{4'hF, 32'h0000_3000, 8'd19, 3'd3, 2'b01}, 32'h0000_3098};
    #3;
    chk("rst_outputs", {bus.arready, bus.rvalid, bus.req_valid, bus.rlast, bus.rid, bus.rdata, bus.req_addr}, '0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_arready", bus.arready, 1);
    chk("rst_release_rvalid", bus.rvalid, 0);
    chk("rst_release_req_valid", bus.req_valid, 0);
    // directed bursts with hand-computed final addresses and exact latencies
    foreach (tbl[k]) begin
      r0 = r_beats;
      l0 = rlasts;
      ar_q.push_back(tbl[k].ar);
      drain("tbl_drain");
      chk("tbl_last_addr", last_req_addr, tbl[k].last_addr);
      chk("tbl_beats", r_beats - r0, int'(tbl[k].ar.len) + 1);
      chk("tbl_rlast", rlasts - l0, 1);
      chk("tbl_req_latency", first_req_cyc - ar_cyc, 1);
      chk("tbl_arready_back", rise_cyc - last_req_cyc, 1);
      chk("tbl_rvalid_latency", rv_first_cyc - rsp_first_cyc, 1);
    end
    stall_check("stall", 4'd4, 32'h0000_4000);
    // back-to-back ARs under toggling backpressure
    rready_mode = 2;
    got.delete();
    ar_q.push_back('{4'd1, 32'h0000_0500, 8'd1, 3'd4, 2'b01});
    ar_q.push_back('{4'd2, 32'h0000_0600, 8'd1, 3'd4, 2'b01});
    drain("b2b_drain");
    chk("b2b_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("b2b_rid", got[i].id, i < 2 ? 1 : 2);
      chk("b2b_rlast", got[i].last, i % 2);
    end
    rready_mode = 1;
    // backend data with no outstanding request must vanish
    spur = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("spurious_rvalid", bus.rvalid, 0);
    r0 = r_beats;
    ar_q.push_back('{4'd11, 32'h0000_0900, 8'd0, 3'd4, 2'b01});
    drain("spurious_drain");
    chk("spurious_after_beats", r_beats - r0, 1);
    // reset during beat 2 of an 8-beat burst
    r0 = req_fires;
    n = 0;
    ar_q.push_back('{4'd6, 32'h0000_7000, 8'd7, 3'd4, 2'b01});
    while (req_fires - r0 < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("midrst_reached", n < 100, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus.arready, bus.rvalid, bus.req_valid, bus.rlast, bus.rid, bus.rdata, bus.req_addr}, '0);
    ar_q.delete(); exp_r.delete(); exp_req.delete(); pend.delete();
    ref_seq = 0;
    bk_seq = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_arready", bus.arready, 1);
    chk("midrst_rvalid", bus.rvalid, 0);
    r0 = r_beats;
    l0 = rlasts;
    ar_q.push_back('{4'd10, 32'h0000_8000, 8'd0, 3'd4, 2'b01});
    drain("midrst_fresh_drain");
    chk("midrst_fresh_beats", r_beats - r0, 1);
    chk("midrst_fresh_rlast", rlasts - l0, 1);
    stall_check("midrst_stall", 4'd12, 32'h0000_9000);
    // random bursts with random backpressure on both sides
    rready_mode = 3;
    req_ready_mode = 3;
    for (int t = 0; t < 40; t++) begin
      ra.id = IW'($urandom);
      ra.addr = $urandom;
      ra.len = 8'($urandom_range(0, 20));
      ra.size = 3'($urandom_range(0, 4));
      ra.burst = 2'($urandom);
      ar_q.push_back(ra);
    end
    drain("random_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
